// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential, branch, interrupt, mret),
// IF/ID pipeline register and a RUN/HANDLER tracker that blocks nested interrupts.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_irq_req,
  input  logic [31:0] i_mtvec,
  input  logic        i_mret,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_if_pc,
  output logic        o_valid,
  output logic        o_irq_ack,
  output logic [31:0] o_epc,
  output logic        o_in_handler
);

  typedef enum logic {StRun, StHandler} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic        r_valid;
  logic        r_irq_ack;
  logic [31:0] r_epc;

  logic        w_take;
  logic        w_redirect;
  logic [31:0] w_br_target;
  logic [31:0] w_pc_next;
  logic [31:0] w_epc_next;

  assign w_take      = i_irq_req & (r_state == StRun) & ~i_mret;
  assign w_redirect  = w_take | i_mret | i_br_taken;
  assign w_br_target = {i_br_target[31:2], 2'b00};

  // The older branch completes before the trap, so the handler returns to its target.
  assign w_epc_next  = i_br_taken ? w_br_target : r_pc;

  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (w_take) begin
      w_pc_next = {i_mtvec[31:2], 2'b00};
    end else if (i_mret) begin
      w_pc_next = {i_mepc[31:2], 2'b00};
    end else if (i_br_taken) begin
      w_pc_next = w_br_target;
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StRun;
      r_pc      <= RESET_VECTOR;
      r_instr   <= NOP_INSTR;
      r_if_pc   <= RESET_VECTOR;
      r_valid   <= 1'b0;
      r_irq_ack <= 1'b0;
      r_epc     <= 32'h0;
    end else begin
      r_pc      <= w_pc_next;
      r_irq_ack <= w_take;

      unique case (r_state)
        StRun:     if (w_take) r_state <= StHandler;
        StHandler: if (i_mret) r_state <= StRun;
        default:   r_state <= StRun;
      endcase

      if (w_take) begin
        r_epc <= w_epc_next;
      end

      // A redirect flushes even when stalled; a plain stall freezes IF/ID.
      if (w_redirect) begin
        r_instr <= NOP_INSTR;
        r_if_pc <= r_pc;
        r_valid <= 1'b0;
      end else if (!i_stall) begin
        r_instr <= i_instr;
        r_if_pc <= r_pc;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_pc         = r_pc;
  assign o_instr      = r_instr;
  assign o_if_pc      = r_if_pc;
  assign o_valid      = r_valid;
  assign o_irq_ack    = r_irq_ack;
  assign o_epc        = r_epc;
  assign o_in_handler = (r_state == StHandler);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch, stall, branch, interrupt entry/return, wrap.
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_instr;
  logic        i_stall;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        i_irq_req;
  logic [31:0] i_mtvec;
  logic        i_mret;
  logic [31:0] i_mepc;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [31:0] o_if_pc;
  logic        o_valid;
  logic        o_irq_ack;
  logic [31:0] o_epc;
  logic        o_in_handler;

  int n_chk;
  int n_pass;

  if_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_instr      (i_instr),
    .i_stall      (i_stall),
    .i_br_taken   (i_br_taken),
    .i_br_target  (i_br_target),
    .i_irq_req    (i_irq_req),
    .i_mtvec      (i_mtvec),
    .i_mret       (i_mret),
    .i_mepc       (i_mepc),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .o_if_pc      (o_if_pc),
    .o_valid      (o_valid),
    .o_irq_ack    (o_irq_ack),
    .o_epc        (o_epc),
    .o_in_handler (o_in_handler)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational IMEM: two fixed words at 0 and 4, elsewhere 0xC0 tag over the low address bits.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {8'hC0, a[23:0]};
  endfunction
  assign i_instr = imem(o_pc);

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #3;
    n_chk++; if (o_pc !== 32'h0) $display("FAIL rst_pc got %h want %h", o_pc, 32'h0);
    else n_pass++;
    n_chk++; if (o_instr !== Nop) $display("FAIL rst_instr got %h want %h", o_instr, Nop);
    else n_pass++;
    n_chk++; if ({o_valid, o_irq_ack, o_in_handler} !== 3'b000)
      $display("FAIL rst_flags got %b want 000", {o_valid, o_irq_ack, o_in_handler});
    else n_pass++;
    n_chk++; if ({o_if_pc, o_epc} !== 64'h0) $display("FAIL rst_ifpc_epc got %h %h", o_if_pc, o_epc);
    else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    n_chk++; if ({o_instr, o_if_pc, o_pc, o_valid} !== {32'h0050_0093, 32'h0, 32'h4, 1'b1})
      $display("FAIL rel_edge1 got %h %h %h %b want 00500093 0 4 1", o_instr, o_if_pc, o_pc, o_valid);
    else n_pass++;
    step();
    n_chk++; if ({o_instr, o_if_pc, o_pc} !== {32'h00A0_0113, 32'h4, 32'h8})
      $display("FAIL rel_edge2 got %h %h %h want 00a00113 4 8", o_instr, o_if_pc, o_pc);
    else n_pass++;
  endtask

  task automatic test_stall();
    step();
    step();
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if ({o_pc, o_if_pc, o_instr, o_valid} !== {32'h10, 32'hC, 32'hC000_000C, 1'b1})
        $display("FAIL stall_hold%0d got %h %h %h %b", i, o_pc, o_if_pc, o_instr, o_valid);
      else n_pass++;
    end
    i_stall = 1'b0;
    step();
    n_chk++; if ({o_pc, o_if_pc, o_instr} !== {32'h14, 32'h10, 32'hC000_0010})
      $display("FAIL stall_resume1 got %h %h %h want 14 10 c0000010", o_pc, o_if_pc, o_instr);
    else n_pass++;
    step();
    n_chk++; if ({o_pc, o_if_pc} !== {32'h18, 32'h14})
      $display("FAIL stall_resume2 got %h %h want 18 14", o_pc, o_if_pc);
    else n_pass++;
  endtask

  task automatic test_branch();
    step();
    step();
    i_br_taken = 1'b1;
    i_br_target = 32'h103;
    step();
    i_br_taken = 1'b0;
    n_chk++; if ({o_pc, o_valid, o_instr, o_if_pc} !== {32'h100, 1'b0, Nop, 32'h20})
      $display("FAIL br_redirect got %h %b %h %h want 100 0 13 20", o_pc, o_valid, o_instr, o_if_pc);
    else n_pass++;
    step();
    n_chk++; if ({o_valid, o_if_pc, o_instr, o_pc} !== {1'b1, 32'h100, 32'hC000_0100, 32'h104})
      $display("FAIL br_target got %b %h %h %h want 1 100 c0000100 104", o_valid, o_if_pc, o_instr, o_pc);
    else n_pass++;
  endtask

  task automatic test_irq();
    i_br_taken = 1'b1;
    i_br_target = 32'h40;
    step();
    i_br_taken = 1'b0;
    i_irq_req = 1'b1;
    i_mtvec = 32'h200;
    step();
    n_chk++; if ({o_pc, o_irq_ack, o_epc, o_in_handler} !== {32'h200, 1'b1, 32'h40, 1'b1})
      $display("FAIL irq_take got %h %b %h %b want 200 1 40 1", o_pc, o_irq_ack, o_epc, o_in_handler);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++; if ({o_irq_ack, o_in_handler, o_epc} !== {1'b0, 1'b1, 32'h40})
        $display("FAIL irq_no_nest%0d got %b %b %h want 0 1 40", i, o_irq_ack, o_in_handler, o_epc);
      else n_pass++;
    end
    n_chk++; if (o_pc !== 32'h208) $display("FAIL irq_seq_pc got %h want 208", o_pc);
    else n_pass++;
    i_irq_req = 1'b0;
    i_mret = 1'b1;
    i_mepc = 32'h40;
    step();
    i_mret = 1'b0;
    n_chk++; if ({o_pc, o_in_handler, o_valid} !== {32'h40, 1'b0, 1'b0})
      $display("FAIL mret got %h %b %b want 40 0 0", o_pc, o_in_handler, o_valid);
    else n_pass++;
  endtask

  task automatic test_irq_branch();
    i_irq_req = 1'b1;
    i_br_taken = 1'b1;
    i_br_target = 32'h80;
    step();
    i_irq_req = 1'b0;
    i_br_taken = 1'b0;
    n_chk++; if ({o_pc, o_epc, o_irq_ack} !== {32'h200, 32'h80, 1'b1})
      $display("FAIL irq_br got %h %h %b want 200 80 1", o_pc, o_epc, o_irq_ack);
    else n_pass++;
  endtask

  task automatic test_mret_irq();
    i_mret = 1'b1;
    i_mepc = 32'h300;
    i_irq_req = 1'b1;
    step();
    i_mret = 1'b0;
    n_chk++; if ({o_pc, o_in_handler, o_irq_ack} !== {32'h300, 1'b0, 1'b0})
      $display("FAIL mret_irq_ret got %h %b %b want 300 0 0", o_pc, o_in_handler, o_irq_ack);
    else n_pass++;
    step();
    i_irq_req = 1'b0;
    n_chk++; if ({o_pc, o_in_handler, o_irq_ack, o_epc} !== {32'h200, 1'b1, 1'b1, 32'h300})
      $display("FAIL mret_irq_retake got %h %b %b %h want 200 1 1 300",
               o_pc, o_in_handler, o_irq_ack, o_epc);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step();
    step();
    n_chk++; if ({o_pc, o_in_handler} !== {32'h208, 1'b1})
      $display("FAIL arst_pre got %h %b want 208 1", o_pc, o_in_handler);
    else n_pass++;
    #2;
    i_rst = 1'b1;
    #1;
    n_chk++; if ({o_pc, o_instr, o_if_pc, o_epc} !== {32'h0, Nop, 32'h0, 32'h0})
      $display("FAIL arst_regs got %h %h %h %h want 0 13 0 0", o_pc, o_instr, o_if_pc, o_epc);
    else n_pass++;
    n_chk++; if ({o_valid, o_irq_ack, o_in_handler} !== 3'b000)
      $display("FAIL arst_flags got %b want 000", {o_valid, o_irq_ack, o_in_handler});
    else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    n_chk++; if ({o_pc, o_instr} !== {32'h4, 32'h0050_0093})
      $display("FAIL arst_release got %h %h want 4 00500093", o_pc, o_instr);
    else n_pass++;
  endtask

  task automatic test_wrap_and_misc();
    i_br_taken = 1'b1;
    i_br_target = 32'hFFFF_FFFC;
    step();
    i_br_taken = 1'b0;
    n_chk++; if (o_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_load got %h want fffffffc", o_pc);
    else n_pass++;
    step();
    n_chk++; if ({o_pc, o_if_pc, o_valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1})
      $display("FAIL wrap got %h %h %b want 0 fffffffc 1", o_pc, o_if_pc, o_valid);
    else n_pass++;
    i_mret = 1'b1;
    i_mepc = 32'h52;
    step();
    i_mret = 1'b0;
    n_chk++; if ({o_pc, o_in_handler} !== {32'h50, 1'b0})
      $display("FAIL mret_in_run got %h %b want 50 0", o_pc, o_in_handler);
    else n_pass++;
    i_stall = 1'b1;
    i_irq_req = 1'b1;
    i_mtvec = 32'h201;
    step();
    i_irq_req = 1'b0;
    i_stall = 1'b0;
    n_chk++; if ({o_pc, o_irq_ack, o_epc, o_valid} !== {32'h200, 1'b1, 32'h50, 1'b0})
      $display("FAIL irq_stall got %h %b %h %b want 200 1 50 0", o_pc, o_irq_ack, o_epc, o_valid);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    i_rst = 1'b1;
    i_stall = 1'b0;
    i_br_taken = 1'b0;
    i_br_target = 32'h0;
    i_irq_req = 1'b0;
    i_mtvec = 32'h0;
    i_mret = 1'b0;
    i_mepc = 32'h0;
    test_reset();
    test_stall();
    test_branch();
    test_irq();
    test_irq_branch();
    test_mret_irq();
    test_async_reset();
    test_wrap_and_misc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the interrupt-capable RISC-V core. Holds the program counter, drives it to the instruction memory's combinational read port, and registers the returned word into the IF/ID pipeline register. Selects the next PC from sequential increment, branch/jump redirect, interrupt vector entry or `mret` return. Tracks handler state so that interrupts do not nest.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble word (`addi x0,x0,0`) inserted on reset and flush.
- `i_clk`  in  1  core clock; all state changes on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_instr`  in  32  instruction word from instruction memory for `o_pc`, same cycle.
- `i_stall`  in  1  hold PC and the IF/ID register (hazard unit).
- `i_br_taken`  in  1  branch/jump redirect from execute.
- `i_br_target`  in  32  redirect target.
- `i_irq_req`  in  1  level interrupt request from the interrupt controller.
- `i_mtvec`  in  32  handler entry address.
- `i_mret`  in  1  `mret` resolved in execute.
- `i_mepc`  in  32  return address for `mret`.
- `o_pc`  out  32  current fetch PC, to instruction memory.
- `o_instr`  out  32  IF/ID instruction.
- `o_if_pc`  out  32  IF/ID PC of `o_instr`.
- `o_valid`  out  1  IF/ID entry holds a real instruction.
- `o_irq_ack`  out  1  one-cycle pulse: interrupt taken.
- `o_epc`  out  32  saved return PC, valid while `o_irq_ack`=1.
- `o_in_handler`  out  1  handler FSM is in HANDLER.

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- Reset values: PC=`RESET_VECTOR`, `o_instr`=`NOP_INSTR`, `o_if_pc`=`RESET_VECTOR`, `o_valid`=0, `o_irq_ack`=0, `o_epc`=0, FSM=RUN.
- FSM states: RUN and HANDLER.
  - RUN→HANDLER on an interrupt take.
  - HANDLER→RUN on `i_mret`.
  - `i_irq_req` is ignored in HANDLER.
- Interrupt take is `i_irq_req` & RUN & !`i_mret`. It is taken even when `i_stall`=1, because the flush overrides the stall.
- Next-PC priority, highest first:
  1. Interrupt take: PC←`i_mtvec`. `o_epc`←`i_br_taken` ? `i_br_target` : PC. The older branch completes, so the handler returns to its target.
  2. `i_mret`: PC←`i_mepc`.
  3. `i_br_taken`: PC←`i_br_target`.
  4. `i_stall`: PC holds.
  5. Otherwise PC←PC+4.
- Arithmetic and alignment:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - Bits [1:0] of every loaded target are forced to 0.
- IF/ID register update:
  - On any redirect (cases 1–3): `o_instr`←`NOP_INSTR`, `o_valid`←0, `o_if_pc`←old PC.
  - On stall with no redirect: all three hold.
  - Otherwise: `o_instr`←`i_instr`, `o_if_pc`←PC, `o_valid`←1.
- `o_irq_ack` is registered: it is 1 in the cycle after the take edge, for exactly one cycle. `o_epc` holds its value until the next take.
- Simultaneous events:
  - `i_mret` with `i_irq_req` in HANDLER: the return happens. A still-asserted request is taken on the next cycle in RUN.
  - `i_mret` in RUN: the PC is redirected and the FSM stays in RUN.
- Reset asserted mid-operation clears all state immediately (asynchronous). A pending interrupt is dropped.

## Timing
- `o_pc` is the PC register output directly, with no combinational path from the inputs.
- IMEM read is combinational: `i_instr` belongs to `o_pc` in the same cycle.
- Fetch latency is 1 cycle: PC presented in cycle n appears on `o_instr` and `o_if_pc` after edge n.
- Redirect penalty: one bubble (`o_valid`=0) in IF/ID. The target instruction is valid 2 edges after the redirect inputs are sampled.
- After `i_rst` falls:
  - Edge 1 captures the instruction at `RESET_VECTOR` (`o_valid`=1).
  - PC becomes `RESET_VECTOR`+4.

## Test plan
- Reset release with IMEM words 0x00500093 and 0x00A00113 at addresses 0 and 4 → edge 1: `o_instr`=0x00500093, `o_if_pc`=0, `o_pc`=4. Edge 2: `o_instr`=0x00A00113, `o_if_pc`=4.
- `i_stall`=1 for 3 cycles at PC=0x10 → `o_pc` stays 0x10 and IF/ID is unchanged. Fetch resumes at 0x10 then 0x14.
- `i_br_taken`=1, `i_br_target`=0x103 at PC=0x20 → `o_pc`=0x100. One bubble with `o_valid`=0. Next valid `o_if_pc`=0x100.
- `i_irq_req`=1, `i_mtvec`=0x200 at PC=0x40 → `o_pc`=0x200, `o_irq_ack` pulses once with `o_epc`=0x40, `o_in_handler`=1. A held request causes no second ack. `i_mret` with `i_mepc`=0x40 → `o_pc`=0x40, `o_in_handler`=0.
- `i_irq_req` and `i_br_taken` (target 0x80) in the same cycle → `o_pc`=0x200, `o_epc`=0x80.
- `i_rst` asserted mid-cycle while in HANDLER at PC=0x208 → outputs go to reset values immediately, without a clock edge. `o_in_handler`=0. PC wraps correctly: 0xFFFFFFFC → 0x0.
